vga_sync_decoder: RTL and testbench

//  Receive-side counterpart of the VGA output path. Takes the sync and colour stream a VGA timing

---
 rtl/vga_sync_decoder.sv | 145 ++++++++++++++
 tb/tb_vga_sync_decoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers pixel coordinates, active-video strobe,
// frame-start and lock status from an incoming h/v sync + RGB stream.
module vga_sync_decoder #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit SYNC_ACT   = 1'b0,
  parameter int LOCK_LINES = 4
) (
  input  logic       pixel_clk,
  input  logic       reset,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic [7:0] rgb_in,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic [7:0] rgb_out,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SS    = H_ACTIVE + H_FRONT;
  localparam int V_SS    = V_ACTIVE + V_FRONT;
  localparam int WD_LIM  = 2 * H_TOTAL;
  localparam int WD_W    = $clog2(WD_LIM + 1);
  localparam int LC_W    = $clog2(LOCK_LINES + 1);

  localparam logic [9:0] HSS  = 10'(H_SS);
  localparam logic [9:0] HSS1 = 10'(H_SS + 1);
  localparam logic [9:0] HMAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] HACT = 10'(H_ACTIVE);
  localparam logic [9:0] VSS  = 10'(V_SS);
  localparam logic [9:0] VMAX = 10'(V_TOTAL - 1);
  localparam logic [9:0] VACT = 10'(V_ACTIVE);

  localparam logic [WD_W-1:0] WDL  = WD_W'(WD_LIM);
  localparam logic [WD_W-1:0] WDL1 = WD_W'(WD_LIM - 1);
  localparam logic [LC_W-1:0] LCM  = LC_W'(LOCK_LINES);

  logic            r_hs_q, r_hs_p_q;
  logic            r_vs_q, r_vs_p_q;
  logic [7:0]      r_rgb_q;
  logic [9:0]      h_pos_q, h_pos_d;
  logic [9:0]      v_pos_q, v_pos_d;
  logic [LC_W-1:0] lock_cnt_q, lock_cnt_d;
  logic            v_lock_q, v_lock_d;
  logic            v_seen_q, v_seen_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic       hs_edge, vs_edge, h_wrap, h_lock;
  logic       h_bad, v_bad, v_good, wd_err, err_d, lock_ok;
  logic [9:0] v_exp;

  always_comb begin
    hs_edge = (r_hs_q == SYNC_ACT) && (r_hs_p_q != SYNC_ACT);
    vs_edge = (r_vs_q == SYNC_ACT) && (r_vs_p_q != SYNC_ACT);
    h_wrap  = !hs_edge && (h_pos_q == HMAX);
    h_lock  = (lock_cnt_q == LCM);
    lock_ok = h_lock && v_lock_q;

    h_pos_d = h_wrap ? 10'd0 : h_pos_q + 10'd1;
    if (hs_edge) h_pos_d = HSS1;

    v_pos_d = v_pos_q;
    if (h_wrap) v_pos_d = (v_pos_q == VMAX) ? 10'd0 : v_pos_q + 10'd1;
    if (vs_edge) v_pos_d = VSS;

    // The very first vsync after reset only aligns the vertical counter
    v_exp  = h_wrap ? v_pos_q + 10'd1 : v_pos_q;
    h_bad  = hs_edge && (h_pos_q != HSS);
    v_bad  = vs_edge && v_seen_q && (v_exp != VSS);
    v_good = vs_edge && v_seen_q && (v_exp == VSS) && h_lock;

    wd_err = !hs_edge && (wd_q == WDL1);
    if (hs_edge)          wd_d = '0;
    else if (wd_q == WDL) wd_d = wd_q;
    else                  wd_d = wd_q + WD_W'(1);

    lock_cnt_d = lock_cnt_q;
    if (hs_edge && !h_bad && !h_lock) lock_cnt_d = lock_cnt_q + LC_W'(1);

    v_lock_d = v_lock_q;
    if (v_good) v_lock_d = 1'b1;
    if (v_bad)  v_lock_d = 1'b0;
    if (h_bad || wd_err) begin
      lock_cnt_d = '0;
      v_lock_d   = 1'b0;
    end

    v_seen_d = v_seen_q || vs_edge;
    err_d    = h_bad || v_bad || wd_err;
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      r_hs_q      <= ~SYNC_ACT;
      r_hs_p_q    <= ~SYNC_ACT;
      r_vs_q      <= ~SYNC_ACT;
      r_vs_p_q    <= ~SYNC_ACT;
      r_rgb_q     <= '0;
      h_pos_q     <= '0;
      v_pos_q     <= '0;
      lock_cnt_q  <= '0;
      v_lock_q    <= 1'b0;
      v_seen_q    <= 1'b0;
      wd_q        <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      rgb_out     <= '0;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      r_hs_q      <= h_sync;
      r_hs_p_q    <= r_hs_q;
      r_vs_q      <= v_sync;
      r_vs_p_q    <= r_vs_q;
      r_rgb_q     <= rgb_in;
      h_pos_q     <= h_pos_d;
      v_pos_q     <= v_pos_d;
      lock_cnt_q  <= lock_cnt_d;
      v_lock_q    <= v_lock_d;
      v_seen_q    <= v_seen_d;
      wd_q        <= wd_d;
      pixel_x     <= h_pos_q;
      pixel_y     <= v_pos_q;
      rgb_out     <= r_rgb_q;
      pixel_valid <= lock_ok && (h_pos_q < HACT) && (v_pos_q < VACT);
      frame_start <= lock_ok && (h_pos_q == 10'd0) && (v_pos_q == 10'd0);
      locked      <= lock_ok;
      sync_err    <= err_d;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced 25x13 raster
// driven by a small reference sync generator.
module tb_vga_sync_decoder;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam int H_TOTAL = HA + HF + HS + HB;
  localparam int V_TOTAL = VA + VF + VS + VB;
  localparam int H_SS = HA + HF;
  localparam int V_SS = VA + VF;
  localparam int LIMIT = 2 * H_TOTAL;
  localparam bit ACT = 1'b0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       h_sync = ~ACT;
  logic       v_sync = ~ACT;
  logic [7:0] rgb_in = '0;
  logic [9:0] pixel_x, pixel_y;
  logic [7:0] rgb_out;
  logic       pixel_valid, frame_start, locked, sync_err;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, last_hs = 0, first_err = -1, rel = 0;
  int n_valid = 0, n_rgb_bad = 0, n_fs = 0, n_err = 0;
  logic [9:0] fs_x, fs_y;
  logic       fs_v;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACT(ACT), .LOCK_LINES(4)
  ) dut (
    .pixel_clk(clk),
    .reset(rst),
    .h_sync(h_sync),
    .v_sync(v_sync),
    .rgb_in(rgb_in),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .rgb_out(rgb_out),
    .pixel_valid(pixel_valid),
    .frame_start(frame_start),
    .locked(locked),
    .sync_err(sync_err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_valid = 0; n_rgb_bad = 0; n_fs = 0; n_err = 0; first_err = -1;
    fs_x = '0; fs_y = '0; fs_v = 1'b0;
  endtask

  task automatic step(input logic hs, input logic vs,
                      input logic [7:0] rgb);
    h_sync = hs; v_sync = vs; rgb_in = rgb;
    @(posedge clk);
    cyc++;
    #1;
    if (pixel_valid) begin
      n_valid++;
      if (rgb_out != pixel_x[7:0]) n_rgb_bad++;
    end
    if (frame_start) begin
      n_fs++; fs_x = pixel_x; fs_y = pixel_y; fs_v = pixel_valid;
    end
    if (sync_err) begin
      n_err++;
      if (first_err < 0) first_err = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(~ACT, ~ACT, 8'h00);
  endtask

  task automatic gen_cyc(input int hc, input int vc);
    logic hs, vs;
    hs = (hc >= H_SS && hc < H_SS + HS) ? ACT : ~ACT;
    vs = (vc >= V_SS && vc < V_SS + VS) ? ACT : ~ACT;
    step(hs, vs, 8'(hc));
    if (hc == H_SS) last_hs = cyc;
  endtask

  // extra > 0 stretches the front porch, delaying this line's hsync
  task automatic gen_line(input int vc, input int extra,
                          input int c0, input int c1);
    for (int hc = c0; hc < c1; hc++) begin
      if (hc == H_SS) repeat (extra) gen_cyc(H_SS - 1, vc);
      gen_cyc(hc, vc);
    end
  endtask

  task automatic gen_lines(input int v0, input int v1);
    for (int vc = v0; vc < v1; vc++) gen_line(vc, 0, 0, H_TOTAL);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle(n);
    rst = 1'b0;
    rel = cyc;
  endtask

  initial begin
    // 1: reset and watchdog from idle
    do_reset(5);
    chk("reset_outs", {pixel_x, pixel_y, rgb_out, pixel_valid,
        frame_start, locked, sync_err}, 0);
    clr();
    idle(3 * LIMIT);
    chk("wd_idle_delay", first_err - rel, LIMIT);
    chk("wd_idle_once", n_err, 1);
    chk("idle_valid", n_valid, 0);

    // 2/3: preamble frame, frame 1, then measured frame 2
    do_reset(2);
    gen_lines(0, V_TOTAL);
    gen_lines(0, V_TOTAL);
    chk("lock_before_f2", locked, 1);
    clr();
    gen_lines(0, V_TOTAL);
    chk("f2_valid_cnt", n_valid, HA * VA);
    chk("f2_rgb_align", n_rgb_bad, 0);
    chk("f2_no_err", n_err, 0);
    chk("f2_fs_cnt", n_fs, 1);
    chk("f2_fs_xyv", {fs_x, fs_y, fs_v}, 1);
    chk("f2_locked", locked, 1);

    // 4: one hsync delayed by 3 cycles, then relock
    clr();
    gen_lines(0, 3);
    gen_line(3, 3, 0, H_TOTAL);
    chk("late_hs_err", n_err, 1);
    chk("late_hs_unlock", locked, 0);
    gen_lines(4, 9);
    chk("no_lock_wo_vs", locked, 0);
    gen_lines(9, V_TOTAL);
    chk("relock", locked, 1);
    chk("relock_err_once", n_err, 1);

    // 5: syncs stop mid-frame
    clr();
    gen_lines(0, 4);
    chk("pre_stop_lock", locked, 1);
    idle(3 * LIMIT);
    chk("wd_stop_delay", first_err - last_hs, LIMIT + 1);
    chk("wd_stop_once", n_err, 1);
    chk("wd_stop_unlock", locked, 0);

    // 6: reset pulse mid-line after regaining lock
    gen_lines(0, V_TOTAL);
    gen_lines(0, V_TOTAL);
    gen_lines(0, 5);
    gen_line(5, 0, 0, 10);
    chk("pre_rst_lock", locked, 1);
    rst = 1'b1;
    gen_cyc(10, 5);
    chk("midrst_outs", {pixel_x, pixel_y, rgb_out, pixel_valid,
        frame_start, locked, sync_err}, 0);
    rst = 1'b0;
    gen_line(5, 0, 11, H_TOTAL);
    gen_lines(6, V_TOTAL);
    gen_lines(0, V_TOTAL);
    chk("rec_locked", locked, 1);
    clr();
    gen_lines(0, V_TOTAL);
    chk("rec_valid_cnt", n_valid, HA * VA);
    chk("rec_rgb_align", n_rgb_bad, 0);
    chk("rec_fs_cnt", n_fs, 1);
    chk("rec_no_err", n_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
